// File: rtl/tetris_vga_pkg.sv
// Shared VGA timing types and the 1024x768@60 constant set used by the raster
// timing generator and the field renderer's placement constants.
package tetris_vga_pkg;

    typedef struct packed {
        int h_active;
        int h_fp;
        int h_sync;
        int h_bp;
        int v_active;
        int v_fp;
        int v_sync;
        int v_bp;
    } vga_timing_t;

    localparam vga_timing_t VGA_1024X768 = '{
        h_active: 1024, h_fp: 24, h_sync: 136, h_bp: 160,
        v_active: 768,  v_fp: 3,  v_sync: 6,   v_bp: 29
    };

endpackage

// File: rtl/vga_pix_timing_if.sv
// Raster timing bundle: pixel strobe in, coordinates and delayed syncs out.
interface vga_pix_timing_if #(
    parameter int PIX_WIDTH = 12
);
    logic                 pix_en_i;
    logic [PIX_WIDTH-1:0] pix_x_o;
    logic [PIX_WIDTH-1:0] pix_y_o;
    logic                 pix_active_o;
    logic                 frame_start_o;
    logic                 hsync_o;
    logic                 vsync_o;
    logic                 de_o;
    logic [15:0]          frame_cnt_o;

    modport master (
        input  pix_en_i,
        output pix_x_o, pix_y_o, pix_active_o, frame_start_o,
               hsync_o, vsync_o, de_o, frame_cnt_o
    );

    modport slave (
        output pix_en_i,
        input  pix_x_o, pix_y_o, pix_active_o, frame_start_o,
               hsync_o, vsync_o, de_o, frame_cnt_o
    );
endinterface

// File: rtl/vga_sync_delay.sv
// Generic WIDTH x DEPTH shift register with enable and async reset to INIT.
module vga_sync_delay #(
    parameter int               WIDTH = 3,
    parameter int               DEPTH = 1,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o
);
    logic [DEPTH-1:0][WIDTH-1:0] pipe;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pipe <= {DEPTH{INIT}};
        end else if (en_i) begin
            for (int i = DEPTH - 1; i > 0; i--) pipe[i] <= pipe[i-1];
            pipe[0] <= din_i;
        end
    end

    assign dout_o = pipe[DEPTH-1];
endmodule

// File: rtl/vga_pix_timing.sv
// Raster timing generator: pixel/line counters, sync decode, SYNC_DELAY-aligned
// hsync/vsync/de. Optional frame counter under `VGA_TIMING_FRAME_CNT_EN.
module vga_pix_timing
    import tetris_vga_pkg::*;
#(
    parameter int PIX_WIDTH  = 12,
    parameter int H_ACTIVE   = VGA_1024X768.h_active,
    parameter int H_FP       = VGA_1024X768.h_fp,
    parameter int H_SYNC     = VGA_1024X768.h_sync,
    parameter int H_BP       = VGA_1024X768.h_bp,
    parameter int V_ACTIVE   = VGA_1024X768.v_active,
    parameter int V_FP       = VGA_1024X768.v_fp,
    parameter int V_SYNC     = VGA_1024X768.v_sync,
    parameter int V_BP       = VGA_1024X768.v_bp,
    parameter bit HSYNC_POL  = 1'b0,
    parameter bit VSYNC_POL  = 1'b0,
    parameter int SYNC_DELAY = 1
) (
    input logic               clk_i,
    input logic               rst_n_i,
    vga_pix_timing_if.master  vif
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    generate
        if (H_TOTAL > 2**PIX_WIDTH || V_TOTAL > 2**PIX_WIDTH) begin : g_bad_total
            $error("vga_pix_timing: H_TOTAL/V_TOTAL exceed 2**PIX_WIDTH");
        end
        if (SYNC_DELAY < 1 || SYNC_DELAY > 8) begin : g_bad_delay
            $error("vga_pix_timing: SYNC_DELAY must be 1..8");
        end
    endgenerate

    // One extra bit so a decode boundary equal to 2**PIX_WIDTH stays representable
    localparam logic [PIX_WIDTH:0] H_ACT  = (PIX_WIDTH+1)'(H_ACTIVE);
    localparam logic [PIX_WIDTH:0] HS_BEG = (PIX_WIDTH+1)'(H_ACTIVE + H_FP);
    localparam logic [PIX_WIDTH:0] HS_END = (PIX_WIDTH+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [PIX_WIDTH:0] V_ACT  = (PIX_WIDTH+1)'(V_ACTIVE);
    localparam logic [PIX_WIDTH:0] VS_BEG = (PIX_WIDTH+1)'(V_ACTIVE + V_FP);
    localparam logic [PIX_WIDTH:0] VS_END = (PIX_WIDTH+1)'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [PIX_WIDTH-1:0] X_LAST = PIX_WIDTH'(H_TOTAL - 1);
    localparam logic [PIX_WIDTH-1:0] Y_LAST = PIX_WIDTH'(V_TOTAL - 1);

    logic [PIX_WIDTH-1:0] pix_x, pix_y;
    logic [PIX_WIDTH:0]   x_ext, y_ext;
    logic                 pix_en;
    logic                 hs_raw, vs_raw, act_raw;
    logic [2:0]           sync_dly;

    assign pix_en = vif.pix_en_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pix_x <= '0;
            pix_y <= '0;
        end else if (pix_en) begin
            if (pix_x == X_LAST) begin
                pix_x <= '0;
                pix_y <= (pix_y == Y_LAST) ? '0 : pix_y + 1'b1;
            end else begin
                pix_x <= pix_x + 1'b1;
            end
        end
    end

    assign x_ext   = {1'b0, pix_x};
    assign y_ext   = {1'b0, pix_y};
    assign hs_raw  = (x_ext >= HS_BEG) && (x_ext < HS_END);
    assign vs_raw  = (y_ext >= VS_BEG) && (y_ext < VS_END);
    assign act_raw = (x_ext < H_ACT) && (y_ext < V_ACT);

    // Raw (unpolarised) flags travel down the line; zero means inactive.
    vga_sync_delay #(
        .WIDTH (3),
        .DEPTH (SYNC_DELAY),
        .INIT  (3'b000)
    ) u_sync_delay (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .en_i    (pix_en),
        .din_i   ({hs_raw, vs_raw, act_raw}),
        .dout_o  (sync_dly)
    );

    assign vif.pix_x_o       = pix_x;
    assign vif.pix_y_o       = pix_y;
    assign vif.pix_active_o  = act_raw;
    assign vif.frame_start_o = (pix_x == '0) && (pix_y == '0) && pix_en;
    assign vif.hsync_o       = sync_dly[2] ? HSYNC_POL : ~HSYNC_POL;
    assign vif.vsync_o       = sync_dly[1] ? VSYNC_POL : ~VSYNC_POL;
    assign vif.de_o          = sync_dly[0];

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] frame_cnt;
    logic        frame_wrap;

    assign frame_wrap = pix_en && (pix_x == X_LAST) && (pix_y == Y_LAST);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)        frame_cnt <= '0;
        else if (frame_wrap) frame_cnt <= frame_cnt + 16'd1;
    end

    assign vif.frame_cnt_o = frame_cnt;
`else
    assign vif.frame_cnt_o = 16'd0;
`endif
endmodule

// File: tb/tb_vga_pix_timing.sv
// Directed bench for vga_pix_timing: 16x8 raster, SYNC_DELAY=2.
module tb_vga_pix_timing;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

`ifdef VGA_TIMING_FRAME_CNT_EN
    localparam int FC = 1;
`else
    localparam int FC = 0;
`endif

    vga_pix_timing_if #(.PIX_WIDTH(4)) vif ();

    vga_pix_timing #(
        .PIX_WIDTH (4),
        .H_ACTIVE  (8), .H_FP (2), .H_SYNC (3), .H_BP (3),
        .V_ACTIVE  (4), .V_FP (1), .V_SYNC (2), .V_BP (1),
        .HSYNC_POL (1'b0), .VSYNC_POL (1'b0),
        .SYNC_DELAY(2)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .vif     (vif.master)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s obs=%0d exp=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    int hs_cnt, vs_cnt, de_cnt, fs_cnt, hs_line0;

    initial begin
        vif.pix_en_i = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_x", vif.pix_x_o, 0);
        chk("rst_y", vif.pix_y_o, 0);
        chk("rst_hs", vif.hsync_o, 1);
        chk("rst_vs", vif.vsync_o, 1);
        chk("rst_de", vif.de_o, 0);
        chk("rst_fs_en0", vif.frame_start_o, 0);
        chk("rst_fc", vif.frame_cnt_o, 0);
        @(negedge clk);
        vif.pix_en_i = 1'b1;
        #1;
        chk("rst_fs_en1", vif.frame_start_o, 1);
        rst_n = 1'b1;

        hs_cnt = 0; vs_cnt = 0; de_cnt = 0; fs_cnt = 0; hs_line0 = 0;
        // sample n = state after n strobes since release
        for (int n = 0; n <= 421; n++) begin
            if (n < 128) begin
                hs_cnt += (vif.hsync_o == 1'b0) ? 1 : 0;
                vs_cnt += (vif.vsync_o == 1'b0) ? 1 : 0;
                de_cnt += vif.de_o ? 1 : 0;
                fs_cnt += vif.frame_start_o ? 1 : 0;
                if (n < 16) hs_line0 += (vif.hsync_o == 1'b0) ? 1 : 0;
            end
            case (n)
                0:   begin chk("n0_x", vif.pix_x_o, 0); chk("n0_y", vif.pix_y_o, 0);
                           chk("n0_fs", vif.frame_start_o, 1); chk("n0_de", vif.de_o, 0); end
                1:   begin chk("n1_x", vif.pix_x_o, 1); chk("n1_fs", vif.frame_start_o, 0);
                           chk("n1_de", vif.de_o, 0); end
                2:   chk("n2_de", vif.de_o, 1);
                9:   chk("n9_de", vif.de_o, 1);
                10:  chk("n10_de", vif.de_o, 0);
                11:  chk("n11_hs", vif.hsync_o, 1);
                12:  chk("n12_hs", vif.hsync_o, 0);
                14:  chk("n14_hs", vif.hsync_o, 0);
                15:  begin chk("n15_x", vif.pix_x_o, 15); chk("n15_y", vif.pix_y_o, 0);
                           chk("n15_hs", vif.hsync_o, 1); end
                16:  begin chk("n16_x", vif.pix_x_o, 0); chk("n16_y", vif.pix_y_o, 1);
                           chk("n16_fs", vif.frame_start_o, 0); end
                66:  chk("n66_de", vif.de_o, 0);
                81:  chk("n81_vs", vif.vsync_o, 1);
                82:  chk("n82_vs", vif.vsync_o, 0);
                113: chk("n113_vs", vif.vsync_o, 0);
                114: chk("n114_vs", vif.vsync_o, 1);
                127: begin chk("n127_x", vif.pix_x_o, 15); chk("n127_y", vif.pix_y_o, 7);
                           chk("n127_fc", vif.frame_cnt_o, 0); end
                128: begin chk("n128_x", vif.pix_x_o, 0); chk("n128_y", vif.pix_y_o, 0);
                           chk("n128_fs", vif.frame_start_o, 1);
                           chk("n128_fc", vif.frame_cnt_o, 32'(FC)); end
                129: begin chk("hs_frame_cnt", hs_cnt, 24); chk("hs_line0_cnt", hs_line0, 3);
                           chk("vs_frame_cnt", vs_cnt, 32); chk("de_frame_cnt", de_cnt, 32);
                           chk("fs_frame_cnt", fs_cnt, 1); end
                256: chk("n256_fc", vif.frame_cnt_o, 32'(2 * FC));
                384: begin chk("n384_fc", vif.frame_cnt_o, 32'(3 * FC));
                           chk("n384_x", vif.pix_x_o, 0); chk("n384_y", vif.pix_y_o, 0); end
                421: begin
                    chk("pre_rst_x", vif.pix_x_o, 5);
                    chk("pre_rst_y", vif.pix_y_o, 2);
                    chk("pre_rst_de", vif.de_o, 1);
                    rst_n = 1'b0;
                    #1;
                    chk("mid_rst_x", vif.pix_x_o, 0);
                    chk("mid_rst_y", vif.pix_y_o, 0);
                    chk("mid_rst_hs", vif.hsync_o, 1);
                    chk("mid_rst_vs", vif.vsync_o, 1);
                    chk("mid_rst_de", vif.de_o, 0);
                    chk("mid_rst_fc", vif.frame_cnt_o, 0);
                end
                default: ;
            endcase
            @(negedge clk);
            #1;
        end

        // strobe every other cycle: strobes seen at sample m = (m+1)/2
        rst_n = 1'b1;
        for (int m = 0; m <= 29; m++) begin
            vif.pix_en_i = (m % 2 == 0);
            #1;
            case (m)
                0:  begin chk("tg0_x", vif.pix_x_o, 0); chk("tg0_y", vif.pix_y_o, 0);
                          chk("tg0_fs", vif.frame_start_o, 1); end
                1:  begin chk("tg1_x", vif.pix_x_o, 1); chk("tg1_fs", vif.frame_start_o, 0); end
                2:  begin chk("tg2_x", vif.pix_x_o, 1); chk("tg2_de", vif.de_o, 0); end
                3:  begin chk("tg3_x", vif.pix_x_o, 2); chk("tg3_de", vif.de_o, 1); end
                4:  begin chk("tg4_x", vif.pix_x_o, 2); chk("tg4_de", vif.de_o, 1); end
                22: chk("tg22_hs", vif.hsync_o, 1);
                23: chk("tg23_hs", vif.hsync_o, 0);
                24: chk("tg24_hs", vif.hsync_o, 0);
                25: chk("tg25_x", vif.pix_x_o, 13);
                26: chk("tg26_hs", vif.hsync_o, 0);
                28: chk("tg28_hs", vif.hsync_o, 0);
                29: chk("tg29_hs", vif.hsync_o, 1);
                default: ;
            endcase
            @(negedge clk);
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
